reg_writeback: RTL and testbench

//  Write-side front end for the 8x8 register file: accepts results from the ALU and load paths,

---
 rtl/wb_pkg.sv | 20 ++
 rtl/wb_fifo.sv | 81 ++++++++
 rtl/reg_writeback.sv | 99 +++++++++
 tb/tb_reg_writeback.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback front end.
// Entry layout and register-count helpers used by the FIFO and the top.
package wb_pkg;

    localparam int DATA_W   = 8;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(
        input logic [ADDR_W-1:0] rd
    );
        return NUM_REGS'(1) << rd;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order result queue feeding the regfile write port.
// Exposes per-slot valid and destination for the pending scoreboard.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  wb_entry_t                    push_entry,
    input  logic                         pop,
    input  logic                         flush,
    output wb_entry_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [CNT_W-1:0]             count,
    output logic [DEPTH-1:0]             entry_vld,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_rd
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] cnt;
    logic [DEPTH-1:0] vld;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rptr];
    assign count   = cnt;
    assign entry_vld = vld;

    // Gather slot destinations for the scoreboard reduction.
    always_comb begin
        entry_rd = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_rd[i] = mem[i].rd;
        end
    end

    // Queue state: flush wins over push/pop; pointers wrap naturally.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            vld  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            vld  <= '0;
        end else begin
            if (push_ok) begin
                mem[wptr] <= push_entry;
                vld[wptr] <= 1'b1;
                wptr      <= wptr + 1'b1;
            end
            if (pop_ok) begin
                vld[rptr] <= 1'b0;
                rptr      <= rptr + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Regfile write-side front end: load/ALU arbitration, result queue,
// host-priority write port mux and per-register pending scoreboard.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      ld_valid,
    output logic                      ld_ready,
    input  logic [ADDR_W-1:0]         ld_rd,
    input  logic [DATA_W-1:0]         ld_data,
    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [ADDR_W-1:0]         alu_rd,
    input  logic [DATA_W-1:0]         alu_data,
    input  logic                      host_wr,
    input  logic [ADDR_W-1:0]         host_rd,
    input  logic [DATA_W-1:0]         host_data,
    input  logic                      flush,
    output logic                      write,
    output logic [ADDR_W-1:0]         wR,
    output logic [DATA_W-1:0]         dataIn,
    output logic [NUM_REGS-1:0]       pending,
    output logic [$clog2(DEPTH):0]    count
);

    wb_entry_t                    push_entry;
    wb_entry_t                    head;
    logic                         push;
    logic                         pop;
    logic                         full;
    logic                         empty;
    logic [DEPTH-1:0]             entry_vld;
    logic [DEPTH-1:0][ADDR_W-1:0] entry_rd;

    assign ld_ready  = ~full & ~flush;
    assign alu_ready = ~full & ~flush & ~ld_valid;
    assign push      = (ld_valid & ld_ready) | (alu_valid & alu_ready);

    // Load path has fixed priority over the ALU for the single enqueue slot.
    always_comb begin
        push_entry = '0;
        if (ld_valid) begin
            push_entry.rd   = ld_rd;
            push_entry.data = ld_data;
        end else begin
            push_entry.rd   = alu_rd;
            push_entry.data = alu_data;
        end
    end

    // Write port: host first, otherwise drain the queue head.
    always_comb begin
        write  = 1'b0;
        wR     = '0;
        dataIn = '0;
        pop    = 1'b0;
        if (host_wr) begin
            write  = 1'b1;
            wR     = host_rd;
            dataIn = host_data;
        end else if (!empty && !flush) begin
            write  = 1'b1;
            wR     = head.rd;
            dataIn = head.data;
            pop    = 1'b1;
        end
    end

    // Scoreboard: OR of destinations of all live queue slots.
    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_vld[i]) begin
                pending = pending | rd_onehot(entry_rd[i]);
            end
        end
    end

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (flush),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .count      (count),
        .entry_vld  (entry_vld),
        .entry_rd   (entry_rd)
    );

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: inputs change on the falling edge,
// outputs are checked 1ns later, a regfile model captures commits.
module tb_reg_writeback;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ld_valid;
    logic       ld_ready;
    logic [2:0] ld_rd;
    logic [7:0] ld_data;
    logic       alu_valid;
    logic       alu_ready;
    logic [2:0] alu_rd;
    logic [7:0] alu_data;
    logic       host_wr;
    logic [2:0] host_rd;
    logic [7:0] host_data;
    logic       flush;
    logic       write;
    logic [2:0] wR;
    logic [7:0] dataIn;
    logic [7:0] pending;
    logic [2:0] count;

    logic [7:0] rf [8];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_writeback #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_rd     (ld_rd),
        .ld_data   (ld_data),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .host_wr   (host_wr),
        .host_rd   (host_rd),
        .host_data (host_data),
        .flush     (flush),
        .write     (write),
        .wR        (wR),
        .dataIn    (dataIn),
        .pending   (pending),
        .count     (count)
    );

    // Regfile model driven by the DUT write port.
    always @(posedge clk) begin
        if (write) rf[wR] <= dataIn;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rf[i] = 8'h00;
        reset_n = 1'b0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        host_wr = 0; host_rd = 0; host_data = 0;
        flush = 0;
        #1;
        chk("rst_write", write, 0);
        chk("rst_count", count, 0);
        chk("rst_pending", pending, 0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // single ALU result
        @(negedge clk);
        alu_valid = 1; alu_rd = 5; alu_data = 8'h3C;
        #1;
        chk("t2_ready", alu_ready, 1);
        chk("t2_nowrite", write, 0);
        @(negedge clk);
        alu_valid = 0;
        #1;
        chk("t2_write", write, 1);
        chk("t2_wR", wR, 5);
        chk("t2_data", dataIn, 8'h3C);
        chk("t2_pend", pending, 8'h20);
        chk("t2_count", count, 1);
        @(negedge clk);
        #1;
        chk("t2_idle", write, 0);
        chk("t2_pend0", pending, 0);
        chk("t2_rf5", rf[5], 8'h3C);

        // load beats ALU
        @(negedge clk);
        ld_valid = 1; ld_rd = 2; ld_data = 8'hA1;
        alu_valid = 1; alu_rd = 3; alu_data = 8'hB2;
        #1;
        chk("t3_ldrdy", ld_ready, 1);
        chk("t3_alurdy", alu_ready, 0);
        @(negedge clk);
        ld_valid = 0;
        #1;
        chk("t3_alurdy2", alu_ready, 1);
        chk("t3_wR0", wR, 2);
        chk("t3_d0", dataIn, 8'hA1);
        @(negedge clk);
        alu_valid = 0;
        #1;
        chk("t3_write1", write, 1);
        chk("t3_wR1", wR, 3);
        chk("t3_d1", dataIn, 8'hB2);
        @(negedge clk);
        #1;
        chk("t3_idle", write, 0);

        // backpressure behind host writes
        host_wr = 1; host_rd = 0; host_data = 8'h55;
        alu_valid = 1;
        for (int i = 0; i < 6; i++) begin
            alu_rd = 3'(4 + i);
            alu_data = 8'(8'h40 + i);
            #1;
            chk("t4_ready", alu_ready, (i < 4) ? 1 : 0);
            chk("t4_count", count, (i < 4) ? i : 4);
            chk("t4_hostwr", wR, 0);
            @(negedge clk);
        end
        host_wr = 0; alu_valid = 0;
        #1;
        chk("t4_full", count, 4);
        chk("t4_ldblk", ld_ready, 0);
        chk("t4_pend", pending, 8'hF0);
        for (int k = 0; k < 4; k++) begin
            chk("t4_cwr", write, 1);
            chk("t4_cwR", wR, 4 + k);
            chk("t4_cd", dataIn, 8'h40 + k);
            @(negedge clk);
            #1;
        end
        chk("t4_empty", count, 0);
        chk("t4_rf0", rf[0], 8'h55);
        chk("t4_rf7", rf[7], 8'h43);

        // same-register ordering
        @(negedge clk);
        alu_valid = 1; alu_rd = 1; alu_data = 8'h11;
        @(negedge clk);
        alu_data = 8'h22;
        #1;
        chk("t5_d0", dataIn, 8'h11);
        chk("t5_rdy", alu_ready, 1);
        @(negedge clk);
        alu_valid = 0;
        #1;
        chk("t5_wR", wR, 1);
        chk("t5_d1", dataIn, 8'h22);
        chk("t5_pend", pending, 8'h02);
        @(negedge clk);
        #1;
        chk("t5_rf1", rf[1], 8'h22);
        chk("t5_pend0", pending, 0);

        // flush with concurrent host write
        host_wr = 1; host_rd = 6; host_data = 8'h66;
        alu_valid = 1;
        for (int i = 0; i < 3; i++) begin
            alu_rd = 3'(2 + i);
            alu_data = 8'(8'hC0 + i);
            @(negedge clk);
        end
        alu_valid = 0;
        #1;
        chk("t6_q3", count, 3);
        chk("t6_pend", pending, 8'h1C);
        flush = 1; host_rd = 7; host_data = 8'hFF;
        #1;
        chk("t6_hwr", write, 1);
        chk("t6_hwR", wR, 7);
        chk("t6_hd", dataIn, 8'hFF);
        chk("t6_ldblk", ld_ready, 0);
        @(negedge clk);
        flush = 0; host_wr = 0;
        #1;
        chk("t6_count", count, 0);
        chk("t6_pend0", pending, 0);
        chk("t6_nowr", write, 0);
        chk("t6_rf7", rf[7], 8'hFF);
        chk("t6_rf2", rf[2], 8'hA1);
        @(negedge clk);
        #1;
        chk("t6_still", write, 0);

        // async reset with three queued entries
        host_wr = 1; host_rd = 6; host_data = 8'h66;
        alu_valid = 1;
        for (int i = 0; i < 3; i++) begin
            alu_rd = 3'(1 + i);
            alu_data = 8'(8'hD0 + i);
            @(negedge clk);
        end
        alu_valid = 0; host_wr = 0;
        #1;
        chk("t1_q3", count, 3);
        reset_n = 0;
        #1;
        chk("t1_write", write, 0);
        chk("t1_count", count, 0);
        chk("t1_pend", pending, 0);
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        #1;
        chk("t1_nowr", write, 0);
        chk("t1_rf1", rf[1], 8'h22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
